// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage register with valid/ready handshake.
// SKID=1 builds a 2-entry skid buffer whose in_ready_o comes straight from a
// flop, which cuts the ready path between neighbouring stages. SKID=0 builds
// a single register whose ready passes through combinationally.
// out_ctrl_o is gated with out_valid_o, so a bubble never carries live
// control bits such as RegWrite downstream.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occ_o
);

  // The encoding of each state is its occupancy, so occ_o is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   main_data_r;
  logic [CTRL_W-1:0]   main_ctrl_r;
  logic [DATA_W-1:0]   skid_data_r;
  logic [CTRL_W-1:0]   skid_ctrl_r;
  logic                in_ready_r;

  logic                out_valid_s;
  logic                in_ready_s;
  logic                in_fire_s;
  logic                out_fire_s;

  // Handshake decode: ready is registered in skid mode, pass-through otherwise.
  always_comb begin
    out_valid_s = (state_r != ST_EMPTY);
    if (SKID != 0) begin
      in_ready_s = in_ready_r;
    end else begin
      in_ready_s = !out_valid_s || out_ready_i;
    end
    in_fire_s  = in_valid_i && in_ready_s;
    out_fire_s = out_valid_s && out_ready_i;
  end

  // Occupancy FSM with its payload registers; flush beats any transfer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_EMPTY;
      main_data_r <= {DATA_W{1'b0}};
      main_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      in_ready_r  <= 1'b1;
    end else if (flush_i) begin
      // Payload is left alone so out_data_o still shows its last value.
      state_r    <= ST_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_data_r <= in_data_i;
            main_ctrl_r <= in_ctrl_i;
            state_r     <= ST_ONE;
          end
          in_ready_r <= 1'b1;
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_data_r <= in_data_i;
            main_ctrl_r <= in_ctrl_i;
            in_ready_r  <= 1'b1;
          end else if (in_fire_s) begin
            // Unreachable with pass-through ready: there in_fire implies out_fire.
            skid_data_r <= in_data_i;
            skid_ctrl_r <= in_ctrl_i;
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b0;
          end else if (out_fire_s) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_FULL: begin
          // in_ready_r is low here, so only a drain can happen.
          if (out_fire_s) begin
            main_data_r <= skid_data_r;
            main_ctrl_r <= skid_ctrl_r;
            state_r     <= ST_ONE;
            in_ready_r  <= 1'b1;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_EMPTY;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_s;
  assign occ_o       = state_r;
  assign out_data_o  = main_data_r;
  assign out_ctrl_o  = out_valid_s ? main_ctrl_r : {CTRL_W{1'b0}};

endmodule
